apb_completer_regs: RTL
=======================

Name: apb_completer_regs

Overview:
- APB completer (slave) that answers the transfers issued by the team's APB driver through the apb_if clocking block.
- Contains a bank of NUM_REGS 32-bit read/write registers.
- Inserts a programmable number of wait states.
- Flags illegal accesses.
- Sits behind the apb_if interface as the DUT for the UVM APB environment, and as a reusable peripheral register block.

Parameters:
- ADDR_W, 32, width of PADDR.
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
- WAIT_STATES, 0, PREADY-low cycles inserted in each access phase; 0..15.

Ports:
- PCLK, in, 1, APB clock; all state updates on its rising edge.
- PRESETn, in, 1, asynchronous active-low reset.
- PSEL, in, 1, completer select.
- PENABLE, in, 1, access-phase indicator.
- PWRITE, in, 1, 1 = write, 0 = read.
- PADDR, in, ADDR_W, byte address.
- PWDATA, in, 32, write data.
- PRDATA, out, 32, read data.
- PREADY, out, 1, transfer-complete handshake.
- PSLVERR, out, 1, error response; valid only while PREADY=1.

Behaviour:
- Clocking and reset:
  - One clock, PCLK.
  - PRESETn is asynchronous, active-low.
  - Reset asserted at any time, including mid-transfer:
    - state = IDLE, wait counter = 0.
    - All registers = 0x0000_0000.
    - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - A transfer interrupted by reset is dropped; no register write occurs.
- States:
  - IDLE: PREADY = 0.
    - PSEL=1, PENABLE=0 at an edge → SETUP captured.
    - On that same edge: latch PADDR, PWRITE and PWDATA; load cnt = WAIT_STATES; go to ACCESS.
  - ACCESS:
    - PREADY = (cnt == 0), combinational from registered state.
    - While cnt > 0: each edge with PSEL & PENABLE decrements cnt.
    - Completion edge (PSEL & PENABLE & PREADY): perform the write if legal, then go to IDLE.
    - If PSEL is low at an edge (aborted transfer): return to IDLE with no write.
- Latency: exactly WAIT_STATES cycles with PREADY=0, then one PREADY=1 cycle.
  - WAIT_STATES = 0 gives a 2-cycle transfer (setup + access).
- Back-to-back transfers: after a completion edge, a cycle with PSEL=1, PENABLE=0 is a new SETUP. No idle cycle is required.
- Address decode:
  - index = PADDR[2 +: log2(NUM_REGS)].
  - Legal iff PADDR < NUM_REGS*4 and PADDR[1:0] == 0.
- Write:
  - On the completion edge, reg[index] <= latched PWDATA, only if legal.
  - The value is visible to a read that starts in the next transfer.
- Read:
  - PRDATA = reg[index] while PREADY=1, the latched PWRITE=0, and the address is legal.
  - Otherwise PRDATA = 0.
- Illegal access: no register changes; read data = 0; PSLVERR per Optional Feature.
- Protocol violation: PSEL & PENABLE seen in IDLE with no preceding setup.
  - Respond with PREADY = 1 for that cycle.
  - No write, PRDATA = 0.
  - PSLVERR = 1 when the feature is enabled.
  - Stay in IDLE.
- Address, write and data changes during ACCESS are ignored; the latched values are used.

Optional Feature:
- Macro: APB_COMPLETER_PSLVERR_EN.
- Defined: PSLVERR = 1 in the PREADY=1 cycle of any illegal access or protocol violation; 0 at all other times.
- Undefined: PSLVERR is tied to 0. Illegal accesses still complete silently: no write, read data 0.

Test Plan:
1. Reset, then read all 16 addresses 0x00–0x3C → PRDATA = 0x0 each, PREADY high for 1 cycle, PSLVERR = 0.
2. WAIT_STATES = 0: write 0xDEADBEEF to 0x08, then back-to-back read of 0x08 → each transfer takes 2 cycles; read returns 0xDEADBEEF.
3. WAIT_STATES = 3: write 0x12345678 to 0x3C while PWDATA changes during the wait cycles → PREADY is low for exactly 3 cycles; a later read returns 0x12345678.
4. Access 0x40 and 0x06: write 0xFFFFFFFF, then read → no register changes, read data = 0x0. PSLVERR = 1 with APB_COMPLETER_PSLVERR_EN defined, 0 when it is undefined.
5. WAIT_STATES = 4: drop PRESETn two cycles into a write of 0xA5A5A5A5 to 0x10 → outputs clear immediately; a read of 0x10 after reset returns 0x0.
6. Abort (PSEL drops during the wait states), then PENABLE=1 with no setup → the abort produces no write; the violation gets PREADY = 1 for one cycle with PRDATA = 0, and PSLVERR = 1 when the feature is enabled.

Source files
------------

// File: rtl/apb_completer_regs.sv
// ---------------------------------------------------------------------------
// apb_completer_regs
//
// APB completer with a bank of NUM_REGS 32-bit read/write registers, a fixed
// number of inserted wait states, and flagging of illegal accesses.
//
// Handshake: a transfer begins with a setup cycle (PSEL=1, PENABLE=0) seen in
// IDLE. The next cycles are the access phase. PREADY stays low for
// WAIT_STATES cycles, then is high for one cycle. The edge where
// PSEL & PENABLE & PREADY are all high is the completion edge. Address,
// direction and write data are captured at the setup edge. Later changes on
// those inputs are ignored.
//
// Optional feature (macro APB_COMPLETER_PSLVERR_EN):
//   defined   - PSLVERR=1 in the PREADY=1 cycle of an illegal access or of a
//               protocol violation (PSEL & PENABLE in IDLE without a setup).
//   undefined - PSLVERR is tied to 0. Illegal accesses still complete with no
//               write and read data 0.
//
// Ports:
//   PCLK      in   1       APB clock, rising edge
//   PRESETn   in   1       asynchronous active-low reset
//   PSEL      in   1       completer select
//   PENABLE   in   1       access-phase indicator
//   PWRITE    in   1       1 = write, 0 = read
//   PADDR     in   ADDR_W  byte address
//   PWDATA    in   32      write data
//   PRDATA    out  32      read data (0 unless a legal read completes)
//   PREADY    out  1       transfer-complete handshake
//   PSLVERR   out  1       error response, valid while PREADY=1
//   dbg_state out  1       FSM state (0 = IDLE, 1 = ACCESS)
// ---------------------------------------------------------------------------
module apb_completer_regs #(
    parameter int ADDR_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              dbg_state
);

    localparam int                IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic [ADDR_W-1:0]  lat_addr;
    logic               lat_write;
    logic [31:0]        lat_wdata;
    logic [31:0]        regs [NUM_REGS];
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_legal;
    logic               setup_seen;
    logic               do_write;
    logic               access_rdy;
    logic               violation;

    assign lat_idx   = lat_addr[2 +: IDX_W];
    assign lat_legal = (lat_addr < ADDR_LIMIT) && (lat_addr[1:0] == 2'b00);
    assign dbg_state = state;

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        setup_seen = 1'b0;
        do_write   = 1'b0;
        case (state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup_seen = 1'b1;
                    cnt_nxt    = 4'(WAIT_STATES);
                    state_nxt  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    // Aborted transfer: drop it without touching the bank.
                    state_nxt = S_IDLE;
                end else if (PENABLE) begin
                    if (cnt == 4'd0) begin
                        do_write  = lat_write && lat_legal;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (setup_seen) begin
                lat_addr  <= PADDR;
                lat_write <= PWRITE;
                lat_wdata <= PWDATA;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[lat_idx] <= lat_wdata;
        end
    end

    // A violation is answered combinationally in the same cycle. It is gated
    // by PRESETn so that PREADY stays low while reset is held, even if the
    // requester keeps PSEL/PENABLE up.
    assign access_rdy = (state == S_ACCESS) && (cnt == 4'd0);
    assign violation  = PRESETn && (state == S_IDLE) && PSEL && PENABLE;
    assign PREADY     = access_rdy || violation;
    assign PRDATA     = (access_rdy && !lat_write && lat_legal) ? regs[lat_idx] : 32'h0;

`ifdef APB_COMPLETER_PSLVERR_EN
    assign PSLVERR = (access_rdy && !lat_legal) || violation;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule
